// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb_mux
//  Purpose  : NCH-channel, WIDTH-bit arbitrating mux into a single-entry
//             registered output stage with valid/ready handshake. Arbitration
//             is round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb_mux #(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Registered state
    logic [CHW-1:0]   ptr_q,       ptr_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CHW-1:0]   out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;

    // Combinational arbitration results
    logic             w_load_en;
    logic             w_grant_any;
    logic [CHW-1:0]   w_grant_idx;
    logic             w_xfer;
    int               w_base;
    int               w_search_idx;

    // The output register can take a new word when empty or being drained now
    assign w_load_en = !out_valid_q || out_ready;

    // Grant search: scan offsets from the far end down so the nearest valid
    // channel to the start position wins; fixed priority starts at index 0.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_idx  = '0;
        w_search_idx = 0;
        w_base       = (MODE == 0) ? int'(ptr_q) : 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_search_idx = w_base + k;
            if (w_search_idx >= NCH) begin
                w_search_idx = w_search_idx - NCH;
            end
            if (in_valid[w_search_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = CHW'(w_search_idx);
            end
        end
    end

    assign w_xfer = w_grant_any && w_load_en;

    // One-hot accept toward the granted channel, only when the register can load
    for (genvar i = 0; i < NCH; i++) begin : g_ready
        assign in_ready[i] = w_xfer && (w_grant_idx == CHW'(i));
    end

    // Next-state for output register and round-robin pointer
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (w_xfer) begin
            out_data_d  = in_data[int'(w_grant_idx)*WIDTH +: WIDTH];
            out_ch_d    = w_grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 0) begin
                // Modulo-NCH increment, valid for non-power-of-2 channel counts
                ptr_d = (int'(w_grant_idx) == NCH - 1) ? '0 : CHW'(int'(w_grant_idx) + 1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit registered arbitrating mux; successor to the combinational 2:1/4:1 selectors.
- Selects one of NCH valid/ready input channels per cycle, by round-robin or fixed priority, into a single-entry output register with valid/ready handshake.
- Used where several requesters (fetch, load/store, debug) share one datapath port, e.g. the memory request bus.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NCH, 4, number of input channels (>=1).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CHW, derived: max(1, clog2(NCH)), width of the channel-index output; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request valid.
- in_ready  output  NCH  per-channel accept; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  CHW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, RR pointer=0. Any word held in the output register is discarded. All outputs are held at these values while rst_n is low.
- load_en = !out_valid | out_ready. The output register may load in the same cycle it is drained.
- Grant (combinational from in_valid and pointer):
  - MODE 0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., ptr+NCH-1 mod NCH.
  - MODE 1: lowest i with in_valid[i]=1; the pointer is ignored.
- in_ready[i] = grant[i] & load_en. in_ready depends combinationally on in_valid and out_ready. No in_ready bit is high when no in_valid bit is high.
- Transfer on channel i (in_valid[i] & in_ready[i] at the rising edge):
  - out_data <= channel i data; out_ch <= i; out_valid <= 1.
  - MODE 0: ptr <= (i+1) mod NCH, with wrap from NCH-1 to 0.
- Drain with no new transfer (out_valid & out_ready & no grant): out_valid <= 0. out_data and out_ch keep their last values.
- Stall (out_valid & !out_ready): out_data, out_ch and out_valid hold stable. All in_ready are 0. The pointer holds.
- Latency: a word accepted at edge k is visible at the outputs after edge k. Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous drain and accept: back-to-back. out_valid stays 1 and the new word replaces the old in the same edge.
- A requester may drop in_valid before it is granted. Nothing is latched for it and no fairness state changes.
- NCH=1: behaves as a 1-deep pipeline register. out_ch is always 0. ptr is constant 0.
- Fairness (MODE 0): with all channels continuously valid, each channel is granted exactly once per NCH consecutive transfers.
- Arithmetic: the pointer increment wraps modulo NCH, including non-power-of-2 NCH. The search is correct for non-power-of-2 NCH (e.g. NCH=3).

Test Plan:
- Reset/idle: rst_n=0 then 1, in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 for 5 cycles.
- RR fairness: NCH=4, MODE 0, in_valid=1111, data ch i = 16'h00A0+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 and out_data A0,A1,A2,A3,A0,A1, one per cycle.
- Back-pressure: out_valid=1 holding 16'h1234/ch2, out_ready=0 for 3 cycles with in_valid=1011 -> outputs stable, in_ready=0000. Then out_ready=1 -> next edge loads ch3 (pointer=3) while draining 1234.
- Fixed priority: MODE 1, in_valid=0110 continuous, out_ready=1 -> ch1 granted every cycle and ch2 starved. Drop ch1 -> ch2 granted next cycle.
- Non-power-of-2 wrap: NCH=3, in_valid=101, ptr starts 0 -> grants 0,2,0,2, never index 3.
- Reset mid-operation: out_valid=1, out_data=16'hBEEF; assert rst_n=0 between clock edges -> out_valid, out_data and out_ch go to 0 immediately. After release, the first grant is to ch0 given in_valid=1111.
